multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle RV32I core.
- Sequences the datapath around the shared ALU, the unified instruction/data memory port and the immediate sign extender.
- Decodes the latched instruction's opcode/funct fields and drives every datapath select and write enable, one state per cycle.
- Stalls on a memory-ready handshake and parks in a trap state on an illegal opcode.

Parameters:
- RESET_STATE, 4'd0, state entered on reset (FETCH); must stay 0 in production.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  7  Instr[6:0] from the instruction register.
- funct3  in  3  Instr[14:12].
- zero  in  1  ALU result == 0.
- lt  in  1  signed rs1 < rs2 from the ALU.
- ltu  in  1  unsigned rs1 < rs2 from the ALU.
- mem_ready  in  1  memory has completed the current read or write this cycle.
- pc_write  out  1  PC register enable.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  instruction register and oldPC enable.
- reg_write  out  1  register file write enable.
- result_src  out  2  result mux select: 00 = ALUOut, 01 = MemData, 10 = ALUResult.
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1, 11 = zero.
- alu_src_b  out  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = constant 4.
- alu_op  out  2  ALU operation class: 00 = add, 01 = subtract/compare, 10 = funct-decoded.
- imm_src  out  3  immediate format for the sign extender, using the shared Ext_Imm* codes.
- illegal  out  1  high while in TRAP.
- state  out  4  current state, for debug.

Behaviour:
- Outputs are Moore outputs decoded from state. imm_src is decoded combinationally from opcode in every state; the IR is stable from DECODE to the end of the instruction.
- imm_src mapping:
  - I for load, OP-IMM and JALR; S for store; B for branch; U for LUI and AUIPC; J for JAL.
  - Any other opcode yields I.
- Reset (asynchronous, while rst = 1):
  - state = FETCH.
  - pc_write, mem_write, ir_write, reg_write and illegal are forced to 0 while rst is high.
  - All selects take their FETCH values.
- States and encodings:
  - FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7.
  - ALUWB 8, BRANCH 9, JAL 10, JALR 11, LUI 12, AUIPC 13, TRAP 14.
- FETCH:
  - adr_src = 0, a = PC, b = 4, alu_op = add, result_src = 10.
  - ir_write and pc_write are both equal to mem_ready.
  - Stays in FETCH while mem_ready = 0; goes to DECODE when mem_ready = 1.
- DECODE: a = oldPC, b = Imm, alu_op = add (precomputes the branch/JAL target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR.
  - 0110011 -> EXECR; 0010011 -> EXECI.
  - 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR.
  - 0110111 -> LUI; 0010111 -> AUIPC.
  - Any other opcode -> TRAP.
- MEMADR: a = rs1, b = Imm, alu_op = add. Next is MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: adr_src = 1. Holds until mem_ready = 1, then MEMWB.
- MEMWB: result_src = 01, reg_write = 1, then FETCH.
- MEMWRITE:
  - adr_src = 1; mem_write = 1 in every cycle of the state.
  - Holds until mem_ready = 1, then FETCH.
- EXECR: a = rs1, b = rs2, alu_op = 10, then ALUWB.
- EXECI: a = rs1, b = Imm, alu_op = 10, then ALUWB.
- ALUWB: result_src = 00, reg_write = 1, then FETCH.
- BRANCH:
  - a = rs1, b = rs2, alu_op = 01, result_src = 00; next state is FETCH.
  - pc_write = taken, where taken is decided by funct3:
    - 000 zero; 001 !zero; 100 lt; 101 !lt; 110 ltu; 111 !ltu.
    - 010 and 011 are never taken (no trap).
- JAL: a = oldPC, b = 4, alu_op = add, result_src = 00 (target), pc_write = 1, then ALUWB (writes link = oldPC + 4).
- JALR:
  - Cycle 1 (JALR): a = rs1, b = Imm, alu_op = add, result_src = 10, pc_write = 1.
  - The link must be computed before the PC update is observable, so JALR takes 2 cycles: JALR -> JAL -> ALUWB.
  - In that path the JAL state does not re-write the PC: pc_write in JAL is suppressed when the previous state was JALR.
- LUI: a = zero, b = Imm, alu_op = add, then ALUWB.
- AUIPC: a = oldPC, b = Imm, alu_op = add, then ALUWB.
- TRAP: illegal = 1, all write enables 0. Exited only by reset.
- Reset asserted mid-instruction returns to FETCH immediately; there are no partial writes after rst rises.

Decomposition:
- Shared include (define.v) holds:
  - State encodings.
  - The Ext_Imm* codes (I = 0, S = 1, B = 2, U = 3, J = 4).
  - Opcode constants.
  - The alu_src_a, alu_src_b, result_src and alu_op codes.
- One natural sub-module, branch_cond: combinational funct3/zero/lt/ltu -> taken.

Test Plan:
- Reset held 3 cycles, release, mem_ready = 1 -> state 0 then 1; ir_write = pc_write = 1 in the first FETCH cycle; all enables 0 during reset.
- lw (opcode 0000011) with mem_ready low for 2 cycles in MEMREAD -> sequence 0,1,2,3,3,3,4,0; reg_write only in state 4; imm_src = 0.
- sw with mem_ready delayed 1 cycle -> mem_write = 1 for exactly 2 cycles in state 5; imm_src = 1; reg_write never asserted.
- bne, funct3 = 001:
  - zero = 0 -> pc_write = 1 in state 9.
  - zero = 1 -> pc_write = 0.
  - Both return to FETCH; imm_src = 2.
- jal then jalr:
  - jal: states 1,10,8 with pc_write in 10 and reg_write in 8; imm_src = 4.
  - jalr: states 1,11,10,8 with pc_write only in 11.
- Opcode 1111111 -> TRAP (14), illegal = 1 held for 10 cycles; async rst pulse mid-cycle -> state 0 before the next clk edge.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared encodings and decode helpers for the multi-cycle RV32I control FSM
// Purpose: state encodings, Ext_Imm* immediate codes, opcode and funct3 constants,
//          datapath select codes, the registered control bundle and the pure
//          decode functions used by the controller.
// Ports:   none (package).
package multicycle_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_JALR     = 4'd11,
      S_LUI      = 4'd12,
      S_AUIPC    = 4'd13,
      S_TRAP     = 4'd14
   } state_t;

   localparam logic [2:0] EXT_IMM_I = 3'd0;
   localparam logic [2:0] EXT_IMM_S = 3'd1;
   localparam logic [2:0] EXT_IMM_B = 3'd2;
   localparam logic [2:0] EXT_IMM_U = 3'd3;
   localparam logic [2:0] EXT_IMM_J = 3'd4;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [1:0] SRC_A_PC    = 2'b00;
   localparam logic [1:0] SRC_A_OLDPC = 2'b01;
   localparam logic [1:0] SRC_A_RS1   = 2'b10;
   localparam logic [1:0] SRC_A_ZERO  = 2'b11;

   localparam logic [1:0] SRC_B_RS2  = 2'b00;
   localparam logic [1:0] SRC_B_IMM  = 2'b01;
   localparam logic [1:0] SRC_B_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_MEMDATA   = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   // Everything here is a pure function of the state (plus the JALR history
   // bit), so it can be registered alongside the state itself.
   typedef struct packed {
      logic       adr_src;
      logic       pc_write;
      logic       mem_write;
      logic       reg_write;
      logic       illegal;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
   } ctrl_t;

   function automatic logic [2:0] imm_for_opcode(input logic [6:0] opcode);
      logic [2:0] imm;
      case (opcode)
         OP_STORE:         imm = EXT_IMM_S;
         OP_BRANCH:        imm = EXT_IMM_B;
         OP_LUI, OP_AUIPC: imm = EXT_IMM_U;
         OP_JAL:           imm = EXT_IMM_J;
         default:          imm = EXT_IMM_I;
      endcase
      return imm;
   endfunction

   function automatic state_t next_state(input state_t s, input logic [6:0] opcode,
                                         input logic mem_ready);
      state_t n;
      case (s)
         S_FETCH:  n = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: n = S_MEMADR;
               OP_R:              n = S_EXECR;
               OP_IMM:            n = S_EXECI;
               OP_BRANCH:         n = S_BRANCH;
               OP_JAL:            n = S_JAL;
               OP_JALR:           n = S_JALR;
               OP_LUI:            n = S_LUI;
               OP_AUIPC:          n = S_AUIPC;
               default:           n = S_TRAP;
            endcase
         end
         S_MEMADR:                          n = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:                         n = mem_ready ? S_MEMWB : S_MEMREAD;
         S_MEMWRITE:                        n = mem_ready ? S_FETCH : S_MEMWRITE;
         S_MEMWB, S_ALUWB, S_BRANCH:        n = S_FETCH;
         S_EXECR, S_EXECI, S_LUI, S_AUIPC:  n = S_ALUWB;
         S_JAL:                             n = S_ALUWB;
         // JALR updates the PC first, then reuses JAL to form the link value.
         S_JALR:                            n = S_JAL;
         S_TRAP:                            n = S_TRAP;
         default:                           n = S_FETCH;
      endcase
      return n;
   endfunction

   // FETCH pc_write/ir_write and BRANCH pc_write depend on live inputs and are
   // added outside this table.
   function automatic ctrl_t state_outputs(input state_t s, input logic after_jalr);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.alu_src_a  = SRC_A_PC;
            c.alu_src_b  = SRC_B_FOUR;
            c.alu_op     = ALU_ADD;
            c.result_src = RES_ALURESULT;
         end
         S_DECODE, S_AUIPC: begin
            c.alu_src_a = SRC_A_OLDPC;
            c.alu_src_b = SRC_B_IMM;
         end
         S_MEMADR: begin
            c.alu_src_a = SRC_A_RS1;
            c.alu_src_b = SRC_B_IMM;
         end
         S_MEMREAD:  c.adr_src = 1'b1;
         S_MEMWB: begin
            c.result_src = RES_MEMDATA;
            c.reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            c.adr_src   = 1'b1;
            c.mem_write = 1'b1;
         end
         S_EXECR: begin
            c.alu_src_a = SRC_A_RS1;
            c.alu_src_b = SRC_B_RS2;
            c.alu_op    = ALU_FUNCT;
         end
         S_EXECI: begin
            c.alu_src_a = SRC_A_RS1;
            c.alu_src_b = SRC_B_IMM;
            c.alu_op    = ALU_FUNCT;
         end
         S_ALUWB: begin
            c.result_src = RES_ALUOUT;
            c.reg_write  = 1'b1;
         end
         S_BRANCH: begin
            c.alu_src_a  = SRC_A_RS1;
            c.alu_src_b  = SRC_B_RS2;
            c.alu_op     = ALU_SUB;
            c.result_src = RES_ALUOUT;
         end
         S_JAL: begin
            c.alu_src_a  = SRC_A_OLDPC;
            c.alu_src_b  = SRC_B_FOUR;
            c.result_src = RES_ALUOUT;
            // After JALR the PC already holds rs1 + imm; only the link is formed here.
            c.pc_write   = ~after_jalr;
         end
         S_JALR: begin
            c.alu_src_a  = SRC_A_RS1;
            c.alu_src_b  = SRC_B_IMM;
            c.result_src = RES_ALURESULT;
            c.pc_write   = 1'b1;
         end
         S_LUI: begin
            c.alu_src_a = SRC_A_ZERO;
            c.alu_src_b = SRC_B_IMM;
         end
         S_TRAP:     c.illegal = 1'b1;
         default:    c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - controller <-> datapath signal bundle
// Purpose: groups the instruction fields, ALU flags, memory handshake and all
//          control outputs of the multi-cycle controller.
// Ports:   master = datapath side (drives opcode/funct3/zero/lt/ltu/mem_ready,
//          receives controls); slave = controller side (the reverse).
interface multicycle_ctrl_if;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       zero;
   logic       lt;
   logic       ltu;
   logic       mem_ready;
   logic       pc_write;
   logic       adr_src;
   logic       mem_write;
   logic       ir_write;
   logic       reg_write;
   logic [1:0] result_src;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic [2:0] imm_src;
   logic       illegal;
   logic [3:0] state;

   modport master (
      output opcode, funct3, zero, lt, ltu, mem_ready,
      input  pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
             alu_src_a, alu_src_b, alu_op, imm_src, illegal, state
   );

   modport slave (
      input  opcode, funct3, zero, lt, ltu, mem_ready,
      output pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
             alu_src_a, alu_src_b, alu_op, imm_src, illegal, state
   );
endinterface

// File: rtl/multicycle_ctrl_branch_cond.sv
// rtl/multicycle_ctrl_branch_cond.sv - branch taken decision from funct3 and ALU flags
// Purpose: combinational branch condition evaluation.
// Ports:   funct3 (in, 3), zero/lt/ltu (in, ALU compare flags), taken (out).
module multicycle_ctrl_branch_cond
   import multicycle_ctrl_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       zero,
   input  logic       lt,
   input  logic       ltu,
   output logic       taken
);
   always_comb begin
      taken = 1'b0;
      case (funct3)
         F3_BEQ:  taken = zero;
         F3_BNE:  taken = ~zero;
         F3_BLT:  taken = lt;
         F3_BGE:  taken = ~lt;
         F3_BLTU: taken = ltu;
         F3_BGEU: taken = ~ltu;
         // 010/011 are not branch encodings; treat as never taken.
         default: taken = 1'b0;
      endcase
   end
endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main control FSM of the multi-cycle RV32I core
// Purpose: sequences fetch/decode/execute/memory/writeback one state per cycle,
//          driving every datapath select and write enable.
// Ports:   clk (in, rising edge), rst (in, async active-high),
//          bus (multicycle_ctrl_if.slave: instruction fields, ALU flags,
//          mem_ready in; controls, illegal and debug state out).
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter logic [3:0] RESET_STATE = 4'd0
) (
   input  logic              clk,
   input  logic              rst,
   multicycle_ctrl_if.slave  bus
);
   state_t state_q;
   state_t state_d;
   ctrl_t  ctrl_q;
   logic   taken;
   logic   in_fetch;
   logic   in_branch;

   multicycle_ctrl_branch_cond u_branch_cond (
      .funct3 (bus.funct3),
      .zero   (bus.zero),
      .lt     (bus.lt),
      .ltu    (bus.ltu),
      .taken  (taken)
   );

   assign state_d = next_state(state_q, bus.opcode, bus.mem_ready);

   // Control bundle is registered from the next state so it lines up with state_q.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= state_t'(RESET_STATE);
         ctrl_q  <= state_outputs(state_t'(RESET_STATE), 1'b0);
      end else begin
         state_q <= state_d;
         ctrl_q  <= state_outputs(state_d, state_q == S_JALR);
      end
   end

   assign in_fetch  = (state_q == S_FETCH);
   assign in_branch = (state_q == S_BRANCH);

   // Enables are masked by rst so nothing writes while reset is held, even
   // when mem_ready is high during the reset FETCH state.
   assign bus.ir_write   = ~rst & in_fetch & bus.mem_ready;
   assign bus.pc_write   = ~rst & (ctrl_q.pc_write | (in_fetch & bus.mem_ready) | (in_branch & taken));
   assign bus.mem_write  = ~rst & ctrl_q.mem_write;
   assign bus.reg_write  = ~rst & ctrl_q.reg_write;
   assign bus.illegal    = ~rst & ctrl_q.illegal;
   assign bus.adr_src    = ctrl_q.adr_src;
   assign bus.result_src = ctrl_q.result_src;
   assign bus.alu_src_a  = ctrl_q.alu_src_a;
   assign bus.alu_src_b  = ctrl_q.alu_src_b;
   assign bus.alu_op     = ctrl_q.alu_op;
   assign bus.imm_src    = imm_for_opcode(bus.opcode);
   assign bus.state      = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   multicycle_ctrl_if bus ();

   multicycle_ctrl #(.RESET_STATE(4'd0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One expected cycle: -1 in a select field means "not constrained in this state".
   typedef struct {
      int st;
      int pcw;
      int irw;
      int rw;
      int mw;
      int ill;
      int adr;
      int ra;
      int rb;
      int op;
      int rs;
      int imm;
      bit mr;
   } row_t;

   row_t exp_q[$];
   int   state_trace[$];
   int   pcw_cnt;
   int   mw_cnt;
   int   rw_cnt;
   int   cur_imm;

   task automatic chk(input string name, input int act, input int exp);
      if (exp >= 0) begin
         n_tests++;
         if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
         end
      end
   endtask

   function automatic int exp_imm(input logic [6:0] opc);
      case (opc)
         7'b0100011:             return 1;
         7'b1100011:             return 2;
         7'b0110111, 7'b0010111: return 3;
         7'b1101111:             return 4;
         default:                return 0;
      endcase
   endfunction

   function automatic int exp_taken(input logic [2:0] f3, input bit z, input bit l, input bit lu);
      case (f3)
         3'd0:    return int'(z);
         3'd1:    return int'(!z);
         3'd4:    return int'(l);
         3'd5:    return int'(!l);
         3'd6:    return int'(lu);
         3'd7:    return int'(!lu);
         default: return 0;
      endcase
   endfunction

   function automatic row_t mk(input int st, input int ra, input int rb, input int op, input int rs);
      row_t r;
      r.st = st; r.pcw = 0; r.irw = 0; r.rw = 0; r.mw = 0; r.ill = 0; r.adr = -1;
      r.ra = ra; r.rb = rb; r.op = op; r.rs = rs; r.imm = -1; r.mr = 1'b1;
      return r;
   endfunction

   task automatic step(input row_t r);
      row_t x;
      x = r;
      if (x.st != 0) x.imm = cur_imm;
      bus.mem_ready = x.mr;
      exp_q.push_back(x);
      @(posedge clk);
      #1;
   endtask

   // Instruction-level model: expands one instruction into its expected cycles.
   task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input bit z,
                            input bit l, input bit lu, input int fwait, input int mwait,
                            input int ntrap);
      row_t r;
      cur_imm = exp_imm(opc);
      bus.opcode = opc; bus.funct3 = f3; bus.zero = z; bus.lt = l; bus.ltu = lu;
      for (int i = 0; i < fwait; i++) begin
         r = mk(0, 0, 2, 0, 2); r.adr = 0; r.mr = 1'b0; step(r);
      end
      r = mk(0, 0, 2, 0, 2); r.adr = 0; r.pcw = 1; r.irw = 1; step(r);
      r = mk(1, 1, 1, 0, -1); step(r);
      case (opc)
         7'b0000011: begin
            step(mk(2, 2, 1, 0, -1));
            for (int i = 0; i < mwait; i++) begin
               r = mk(3, -1, -1, -1, -1); r.adr = 1; r.mr = 1'b0; step(r);
            end
            r = mk(3, -1, -1, -1, -1); r.adr = 1; step(r);
            r = mk(4, -1, -1, -1, 1); r.rw = 1; step(r);
         end
         7'b0100011: begin
            step(mk(2, 2, 1, 0, -1));
            for (int i = 0; i < mwait; i++) begin
               r = mk(5, -1, -1, -1, -1); r.adr = 1; r.mw = 1; r.mr = 1'b0; step(r);
            end
            r = mk(5, -1, -1, -1, -1); r.adr = 1; r.mw = 1; step(r);
         end
         7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: begin
            if (opc == 7'b0110011)      step(mk(6, 2, 0, 2, -1));
            else if (opc == 7'b0010011) step(mk(7, 2, 1, 2, -1));
            else if (opc == 7'b0110111) step(mk(12, 3, 1, 0, -1));
            else                        step(mk(13, 1, 1, 0, -1));
            r = mk(8, -1, -1, -1, 0); r.rw = 1; step(r);
         end
         7'b1100011: begin
            r = mk(9, 2, 0, 1, 0); r.pcw = exp_taken(f3, z, l, lu); step(r);
         end
         7'b1101111, 7'b1100111: begin
            if (opc == 7'b1100111) begin
               r = mk(11, 2, 1, 0, 2); r.pcw = 1; step(r);
               r = mk(10, 1, 2, 0, 0); step(r);
            end else begin
               r = mk(10, 1, 2, 0, 0); r.pcw = 1; step(r);
            end
            r = mk(8, -1, -1, -1, 0); r.rw = 1; step(r);
         end
         default: begin
            for (int i = 0; i < ntrap; i++) begin
               r = mk(14, -1, -1, -1, -1); r.ill = 1; step(r);
            end
         end
      endcase
   endtask

   // Compare process: every queued cycle is checked mid-cycle.
   initial begin
      row_t c;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            c = exp_q.pop_front();
            state_trace.push_back(int'(bus.state));
            if (bus.pc_write && bus.state != 4'd0) pcw_cnt++;
            if (bus.mem_write) mw_cnt++;
            if (bus.reg_write) rw_cnt++;
            chk("state",      int'(bus.state),      c.st);
            chk("pc_write",   int'(bus.pc_write),   c.pcw);
            chk("ir_write",   int'(bus.ir_write),   c.irw);
            chk("reg_write",  int'(bus.reg_write),  c.rw);
            chk("mem_write",  int'(bus.mem_write),  c.mw);
            chk("illegal",    int'(bus.illegal),    c.ill);
            chk("adr_src",    int'(bus.adr_src),    c.adr);
            chk("alu_src_a",  int'(bus.alu_src_a),  c.ra);
            chk("alu_src_b",  int'(bus.alu_src_b),  c.rb);
            chk("alu_op",     int'(bus.alu_op),     c.op);
            chk("result_src", int'(bus.result_src), c.rs);
            chk("imm_src",    int'(bus.imm_src),    c.imm);
         end
      end
   end

   task automatic clear_counts();
      state_trace.delete();
      pcw_cnt = 0; mw_cnt = 0; rw_cnt = 0;
   endtask

   task automatic chk_trace(input string name, input int seq[$]);
      chk({name, "_len"}, state_trace.size(), seq.size());
      for (int i = 0; i < seq.size() && i < state_trace.size(); i++)
         chk(name, state_trace[i], seq[i]);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_tests = 0; n_fail = 0; cur_imm = 0;
      clear_counts();
      rst = 1'b1;
      bus.opcode = 7'b0010011; bus.funct3 = 3'd0; bus.zero = 1'b0;
      bus.lt = 1'b0; bus.ltu = 1'b0; bus.mem_ready = 1'b1;

      // Reset held for 3 cycles with mem_ready high: no enables, FETCH selects.
      repeat (3) begin
         @(negedge clk);
         chk("rst_state",     int'(bus.state),      0);
         chk("rst_pc_write",  int'(bus.pc_write),   0);
         chk("rst_ir_write",  int'(bus.ir_write),   0);
         chk("rst_reg_write", int'(bus.reg_write),  0);
         chk("rst_mem_write", int'(bus.mem_write),  0);
         chk("rst_illegal",   int'(bus.illegal),    0);
         chk("rst_adr_src",   int'(bus.adr_src),    0);
         chk("rst_src_a",     int'(bus.alu_src_a),  0);
         chk("rst_src_b",     int'(bus.alu_src_b),  2);
         chk("rst_result",    int'(bus.result_src), 2);
      end
      @(posedge clk);
      #1 rst = 1'b0;

      clear_counts();
      run_instr(7'b0010011, 3'd0, 0, 0, 0, 0, 0, 0);
      chk_trace("addi_seq", '{0, 1, 7, 8});

      clear_counts();
      run_instr(7'b0000011, 3'd2, 0, 0, 0, 0, 2, 0);
      chk_trace("lw_seq", '{0, 1, 2, 3, 3, 3, 4});
      chk("lw_rw_cnt", rw_cnt, 1);
      chk("lw_ret", int'(bus.state), 0);

      clear_counts();
      run_instr(7'b0100011, 3'd2, 0, 0, 0, 1, 1, 0);
      chk("sw_mw_cnt", mw_cnt, 2);
      chk("sw_rw_cnt", rw_cnt, 0);
      chk("sw_ret", int'(bus.state), 0);

      run_instr(7'b0110011, 3'd0, 0, 0, 0, 0, 0, 0);

      clear_counts();
      run_instr(7'b1100011, 3'd1, 0, 0, 0, 0, 0, 0);
      chk("bne_taken_pcw", pcw_cnt, 1);
      clear_counts();
      run_instr(7'b1100011, 3'd1, 1, 0, 0, 0, 0, 0);
      chk("bne_not_taken_pcw", pcw_cnt, 0);
      chk("bne_ret", int'(bus.state), 0);

      run_instr(7'b1100011, 3'd0, 1, 0, 0, 0, 0, 0);
      run_instr(7'b1100011, 3'd4, 0, 1, 0, 0, 0, 0);
      run_instr(7'b1100011, 3'd5, 0, 1, 0, 0, 0, 0);
      run_instr(7'b1100011, 3'd6, 0, 0, 1, 0, 0, 0);
      run_instr(7'b1100011, 3'd7, 0, 0, 0, 0, 0, 0);
      run_instr(7'b1100011, 3'd2, 1, 1, 1, 0, 0, 0);
      run_instr(7'b1100011, 3'd3, 1, 1, 1, 0, 0, 0);

      clear_counts();
      run_instr(7'b1101111, 3'd0, 0, 0, 0, 0, 0, 0);
      chk_trace("jal_seq", '{0, 1, 10, 8});
      chk("jal_pcw", pcw_cnt, 1);
      clear_counts();
      run_instr(7'b1100111, 3'd0, 0, 0, 0, 0, 0, 0);
      chk_trace("jalr_seq", '{0, 1, 11, 10, 8});
      chk("jalr_pcw", pcw_cnt, 1);

      run_instr(7'b0110111, 3'd0, 0, 0, 0, 2, 0, 0);
      run_instr(7'b0010111, 3'd0, 0, 0, 0, 0, 0, 0);

      clear_counts();
      run_instr(7'b1111111, 3'd0, 0, 0, 0, 0, 0, 10);
      chk("trap_hold", int'(bus.state), 14);
      #1 rst = 1'b1;
      #1;
      chk("async_rst_state",   int'(bus.state),    0);
      chk("async_rst_illegal", int'(bus.illegal),  0);
      chk("async_rst_irw",     int'(bus.ir_write), 0);
      chk("async_rst_pcw",     int'(bus.pc_write), 0);
      #1 rst = 1'b0;
      run_instr(7'b0010011, 3'd0, 0, 0, 0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
